// File: rtl/banked_mem_responder_pkg.sv
// Shared constants for the banked memory responder: bank geometry, address
// field positions and read return latency.
package mem_pkg;
    localparam int NUM_BANKS       = 4;
    localparam int RD_LATENCY      = 2;
    localparam int BANK_LSB        = 1;
    localparam int BANK_MSB        = 2;
    localparam int ROW_LSB         = 3;
    localparam int BANK_CYCLES_DEF = 4;
    localparam int CNT_W           = 2;

    function automatic logic [1:0] bank_of(input logic [15:0] a);
        return a[BANK_MSB:BANK_LSB];
    endfunction
endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bus between the cache controller (master) and the
// banked memory responder (slave).
interface banked_mem_responder_if #(parameter int DATA_W = 16);
    logic [15:0]       addr;
    logic [DATA_W-1:0] data_in;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              stall;
    logic [3:0]        busy;
    logic              err;

    modport master (output addr, data_in, wr, rd,
                    input  data_out, rd_valid, stall, busy, err);
    modport slave  (input  addr, data_in, wr, rd,
                    output data_out, rd_valid, stall, busy, err);
endinterface

// File: rtl/banked_mem_responder_bank.sv
// One memory bank: row array, write port, read sample register and the
// occupancy down-counter that blocks new accesses while the bank cycles.
module mem_bank
    import mem_pkg::*;
#(
    parameter int ROW_W       = 13,
    parameter int BANK_CYCLES = BANK_CYCLES_DEF,
    parameter int DATA_W      = 16,
    parameter int BANK_ID     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_dump,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ROW_W-1:0]  i_row,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy
);
    logic [DATA_W-1:0] r_mem [2**ROW_W];
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    // Array and read sample are deliberately unreset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_row] <= i_wdata;
        if (i_re) r_rdata      <= r_mem[i_row];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_cnt <= '0;
        else if (i_we || i_re)    r_cnt <= CNT_W'(BANK_CYCLES - 1);
        else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
    end

    assign o_rdata = r_rdata;
    assign o_busy  = (r_cnt != '0);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (i_dump) begin
            for (int r = 0; r < 2**ROW_W; r++) begin
                if (r_mem[r] != '0)
                    $display("mem dump bank %0d row %0d : %h", BANK_ID, r, r_mem[r]);
            end
        end
    end
`endif
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved responder: request decode, stall/err checks and
// the two-stage read return pipeline.
module banked_mem_responder
    import mem_pkg::*;
#(
    parameter int ROW_W       = 13,
    parameter int BANK_CYCLES = BANK_CYCLES_DEF,
    parameter int DATA_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic createdump,
    banked_mem_responder_if.slave bus
);
    logic [1:0]            w_bank;
    logic [ROW_W-1:0]      w_row;
    logic                  w_req;
    logic                  w_err;
    logic                  w_stall;
    logic                  w_acc;
    logic [NUM_BANKS-1:0]  w_busy;
    logic [DATA_W-1:0]     w_rdata [NUM_BANKS];

    logic [RD_LATENCY-1:0] r_vld;
    logic [1:0]            r_bank1;
    logic [DATA_W-1:0]     r_data;

    assign w_bank  = bank_of(bus.addr);
    assign w_row   = bus.addr[ROW_W+ROW_LSB-1:ROW_LSB];
    assign w_req   = bus.rd | bus.wr;
    assign w_err   = (bus.rd & bus.wr) | (w_req & bus.addr[0]);
    assign w_stall = w_req & ~w_err & w_busy[w_bank];
    assign w_acc   = w_req & ~w_err & ~w_stall;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .ROW_W      (ROW_W),
            .BANK_CYCLES(BANK_CYCLES),
            .DATA_W     (DATA_W),
            .BANK_ID    (b)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_dump (createdump),
            .i_we   (w_acc & bus.wr & (w_bank == 2'(b))),
            .i_re   (w_acc & bus.rd & (w_bank == 2'(b))),
            .i_row  (w_row),
            .i_wdata(bus.data_in),
            .o_rdata(w_rdata[b]),
            .o_busy (w_busy[b])
        );
    end

    // Stage 1 is the bank's own sample register; stage 2 muxes it out here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_bank1 <= '0;
            r_data  <= '0;
        end else begin
            r_vld   <= {r_vld[RD_LATENCY-2:0], w_acc & bus.rd};
            r_bank1 <= w_bank;
            r_data  <= r_vld[0] ? w_rdata[r_bank1] : '0;
        end
    end

    assign bus.data_out = r_data;
    assign bus.rd_valid = r_vld[RD_LATENCY-1];
    assign bus.stall    = w_stall;
    assign bus.busy     = w_busy;
    assign bus.err      = w_err;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Scoreboard bench for banked_mem_responder: reads queue expected data with
// a due cycle; a negedge monitor pops and checks every returned word.
module tb_banked_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic createdump = 1'b0;

    banked_mem_responder_if #(.DATA_W(16)) bus();

    banked_mem_responder #(.ROW_W(13), .BANK_CYCLES(4), .DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .createdump(createdump),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model [bit [15:0]];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        total++;
        if (bus.rd_valid === 1'b1) begin
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rd_valid cyc=%0d data_out=%h required=no return", cyc, bus.data_out);
            end else begin
                e = q.pop_front();
                if (bus.data_out !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL read_return got=%h@%0d required=%h@%0d", bus.data_out, cyc, e.data, e.due);
                end
            end
        end else begin
            if (bus.data_out !== 16'h0) begin
                bad++;
                $display("FAIL data_out_idle got=%h required=0000 cyc=%0d", bus.data_out, cyc);
            end
            if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                bad++;
                $display("FAIL missing_read got rd_valid=%b required data %h at cyc %0d", bus.rd_valid, e.data, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Drives one request for one cycle; acceptance is decided from the expected flags.
    task automatic issue(input logic i_rd, input logic i_wr, input logic [15:0] a,
                         input logic [15:0] d, input logic e_stall, input logic e_err,
                         input bit push);
        exp_t e;
        bus.rd = i_rd;
        bus.wr = i_wr;
        bus.addr = a;
        bus.data_in = d;
        #1;
        total++;
        if (bus.stall !== e_stall) begin
            bad++;
            $display("FAIL stall addr=%h got=%b required=%b", a, bus.stall, e_stall);
        end
        total++;
        if (bus.err !== e_err) begin
            bad++;
            $display("FAIL err addr=%h got=%b required=%b", a, bus.err, e_err);
        end
        if (!e_stall && !e_err) begin
            if (i_rd && push) begin
                e.due = cyc + 2;
                e.data = model[a];
                q.push_back(e);
            end
            if (i_wr) model[a] = d;
        end
        step();
    endtask

    task automatic check_busy(input string name, input logic [3:0] exp);
        total++;
        if (bus.busy !== exp) begin
            bad++;
            $display("FAIL %s busy got=%b required=%b", name, bus.busy, exp);
        end
    endtask

    task automatic test_reset();
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.addr = 16'h0;
        bus.data_in = 16'h0;
        @(negedge clk);
        check_busy("reset", 4'b0000);
        total++;
        if (bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0 || bus.stall !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got rv=%b do=%h st=%b er=%b required all 0",
                     bus.rd_valid, bus.data_out, bus.stall, bus.err);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_interleave();
        issue(0, 1, 16'h0100, 16'h1111, 0, 0, 0); check_busy("il1", 4'b0001);
        issue(0, 1, 16'h0102, 16'h2222, 0, 0, 0); check_busy("il2", 4'b0011);
        issue(0, 1, 16'h0104, 16'h3333, 0, 0, 0); check_busy("il3", 4'b0111);
        issue(0, 1, 16'h0106, 16'h4444, 0, 0, 0); check_busy("il4", 4'b1110);
        idle(1); check_busy("il5", 4'b1100);
        idle(1); check_busy("il6", 4'b1000);
        idle(1); check_busy("il7", 4'b0000);
    endtask

    task automatic test_back_to_back();
        issue(1, 0, 16'h0100, 16'h0, 0, 0, 1);
        issue(1, 0, 16'h0102, 16'h0, 0, 0, 1);
        idle(4);
        issue(1, 0, 16'h0104, 16'h0, 0, 0, 1);
        issue(1, 0, 16'h0106, 16'h0, 0, 0, 1);
        idle(4);
    endtask

    task automatic test_bank_conflict();
        issue(0, 1, 16'h0108, 16'h5555, 0, 0, 0);
        idle(4);
        issue(1, 0, 16'h0100, 16'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) issue(1, 0, 16'h0108, 16'h0, 1, 0, 1);
        issue(1, 0, 16'h0108, 16'h0, 0, 0, 1);
        idle(5);
    endtask

    task automatic test_err();
        issue(0, 1, 16'h0200, 16'hAAAA, 0, 0, 0);
        idle(4);
        issue(1, 1, 16'h0200, 16'h1234, 0, 1, 0);
        check_busy("err_rdwr", 4'b0000);
        issue(0, 1, 16'h0201, 16'h9999, 0, 1, 0);
        check_busy("err_odd", 4'b0000);
        issue(1, 0, 16'h0200, 16'h0, 0, 0, 1);
        issue(1, 1, 16'h0200, 16'h0, 0, 1, 0);
        check_busy("err_busybank", 4'b0001);
        idle(4);
    endtask

    task automatic test_reset_mid();
        issue(1, 0, 16'h0100, 16'h0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_busy("mid_reset", 4'b0000);
        total++;
        if (bus.rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_rd_valid got=%b required=0", bus.rd_valid);
        end
        step();
        rst_n = 1'b1;
        idle(4);
        issue(1, 0, 16'h0100, 16'h0, 0, 0, 1);
        idle(4);
    endtask

    task automatic test_top_row();
        issue(0, 1, 16'h7FFE, 16'hBEEF, 0, 0, 0);
        idle(3);
        issue(1, 0, 16'h7FFE, 16'h0, 0, 0, 1);
        idle(3);
        issue(0, 1, 16'hFFFE, 16'hC0DE, 0, 0, 0);
        idle(3);
        issue(1, 0, 16'hFFFE, 16'h0, 0, 0, 1);
        issue(1, 0, 16'h7FFE, 16'h0, 1, 0, 1);
        idle(5);
    endtask

    initial begin
        test_reset();
        test_interleave();
        test_back_to_back();
        test_bank_conflict();
        test_err();
        test_reset_mid();
        test_top_row();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
